// File: rtl/fb_arb_pkg.sv
// Shared types, constants and the buffer-base helper for the frame buffer arbiter.
package fb_arb_pkg;

    localparam int unsigned ADDR_W            = 23;
    localparam int unsigned BURST_LEN         = 8;
    localparam int unsigned FRAME_WORDS_DEF   = 384000;
    localparam int unsigned MAX_RD_STREAK_DEF = 4;
    localparam int unsigned BUF0_BASE         = 0;
    localparam int unsigned BUF1_BASE         = 384000;

    // Pointers must be able to hold FRAME_WORDS itself (the "frame finished" value).
    localparam int unsigned PTR_W = $clog2(FRAME_WORDS_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_e;

    // Word base address of the buffer selected by sel.
    function automatic logic [ADDR_W-1:0] base(input logic sel);
        logic [ADDR_W-1:0] base_s;
        if (sel) begin
            base_s = ADDR_W'(BUF1_BASE);
        end else begin
            base_s = ADDR_W'(BUF0_BASE);
        end
        return base_s;
    endfunction

endpackage

// File: rtl/fb_burst_ptr.sv
// Burst-granular word pointer inside one frame; clear beats advance.
module fb_burst_ptr
    import fb_arb_pkg::*;
#(
    parameter int unsigned LIMIT = FRAME_WORDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [PTR_W-1:0] count,
    output logic             at_end
);

    localparam logic [PTR_W-1:0] STEP    = PTR_W'(BURST_LEN);
    localparam logic [PTR_W-1:0] END_PTR = PTR_W'(LIMIT);

    logic [PTR_W-1:0] count_r;

    // Pointer register: reset/clear to zero, otherwise step one burst per advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (advance) begin
            count_r <= count_r + STEP;
        end else begin
            count_r <= count_r;
        end
    end

    assign count  = count_r;
    assign at_end = (count_r >= END_PTR);

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates the SDRAM command port between display reads (front buffer)
// and host slide writes (back buffer), with frame-aligned buffer swapping.
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned FRAME_WORDS   = FRAME_WORDS_DEF,
    parameter int unsigned MAX_RD_STREAK = MAX_RD_STREAK_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iNewFrame,
    input  logic              iRD_REQ,
    output logic              oRD_GNT,
    input  logic              iWR_REQ,
    output logic              oWR_GNT,
    input  logic              iWR_START,
    input  logic              iSWAP_REQ,
    output logic              oSWAP_PENDING,
    output logic              oFRONT_SEL,
    output logic              oWR_OVF,
    output logic              oCMD_VALID,
    output logic              oCMD_WRITE,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    input  logic              iCMD_READY,
    input  logic              iBURST_DONE
);

    localparam int unsigned             STREAK_W   = $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0]     STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
    localparam logic [STREAK_W-1:0]     STREAK_ONE = {{(STREAK_W-1){1'b0}}, 1'b1};

    arb_state_e          state_r;
    logic                cmd_valid_r;
    logic                cmd_write_r;
    logic [ADDR_W-1:0]   cmd_addr_r;
    logic                rd_gnt_r;
    logic                wr_gnt_r;
    logic                front_r;
    logic                pend_r;
    logic                ovf_r;
    logic [STREAK_W-1:0] streak_r;

    logic [PTR_W-1:0]    rd_ptr_s;
    logic [PTR_W-1:0]    wr_ptr_s;
    logic                rd_end_s;
    logic                wr_end_s;
    logic                rd_accept_s;
    logic                wr_accept_s;
    logic                pick_rd_s;
    logic                pick_wr_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [ADDR_W-1:0]   wr_addr_s;

    fb_burst_ptr #(.LIMIT(FRAME_WORDS)) u_rd_ptr (
        .clk     (iCLK),
        .rst     (iRST),
        .clear   (iNewFrame),
        .advance (rd_accept_s),
        .count   (rd_ptr_s),
        .at_end  (rd_end_s)
    );

    fb_burst_ptr #(.LIMIT(FRAME_WORDS)) u_wr_ptr (
        .clk     (iCLK),
        .rst     (iRST),
        .clear   (iWR_START),
        .advance (wr_accept_s),
        .count   (wr_ptr_s),
        .at_end  (wr_end_s)
    );

    assign rd_accept_s = (state_r == ISSUE) && iCMD_READY && !cmd_write_r;
    assign wr_accept_s = (state_r == ISSUE) && iCMD_READY &&  cmd_write_r;
    assign rd_addr_s   = base(front_r)  + ADDR_W'(rd_ptr_s);
    assign wr_addr_s   = base(~front_r) + ADDR_W'(wr_ptr_s);

    // Requester selection: reads first, writes when reads are idle/finished or the read streak is exhausted.
    always_comb begin
        pick_wr_s = 1'b0;
        pick_rd_s = 1'b0;
        if (iWR_REQ && !wr_end_s && (!(iRD_REQ && !rd_end_s) || (streak_r == STREAK_MAX))) begin
            pick_wr_s = 1'b1;
        end else if (iRD_REQ && !rd_end_s) begin
            pick_rd_s = 1'b1;
        end else begin
            pick_wr_s = 1'b0;
            pick_rd_s = 1'b0;
        end
    end

    // Command FSM with registered command and grant outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r     <= IDLE;
            cmd_valid_r <= 1'b0;
            cmd_write_r <= 1'b0;
            cmd_addr_r  <= '0;
            rd_gnt_r    <= 1'b0;
            wr_gnt_r    <= 1'b0;
        end else begin
            rd_gnt_r <= 1'b0;
            wr_gnt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_wr_s) begin
                        state_r     <= ISSUE;
                        cmd_valid_r <= 1'b1;
                        cmd_write_r <= 1'b1;
                        cmd_addr_r  <= wr_addr_s;
                    end else if (pick_rd_s) begin
                        state_r     <= ISSUE;
                        cmd_valid_r <= 1'b1;
                        cmd_write_r <= 1'b0;
                        cmd_addr_r  <= rd_addr_s;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ISSUE: begin
                    if (iCMD_READY) begin
                        state_r     <= BUSY;
                        cmd_valid_r <= 1'b0;
                        rd_gnt_r    <= ~cmd_write_r;
                        wr_gnt_r    <= cmd_write_r;
                    end else begin
                        state_r     <= ISSUE;
                    end
                end
                BUSY: begin
                    if (iBURST_DONE) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Read streak: counts reads that went ahead of a waiting write.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            streak_r <= '0;
        end else if (!iWR_REQ || wr_accept_s) begin
            streak_r <= '0;
        end else if (rd_accept_s && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + STREAK_ONE;
        end else begin
            streak_r <= streak_r;
        end
    end

    // Double-buffer control: a pending swap is applied at the next frame start.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            front_r <= 1'b0;
            pend_r  <= 1'b0;
        end else if (iNewFrame && pend_r) begin
            front_r <= ~front_r;
            pend_r  <= iSWAP_REQ;
        end else if (iSWAP_REQ) begin
            front_r <= front_r;
            pend_r  <= 1'b1;
        end else begin
            front_r <= front_r;
            pend_r  <= pend_r;
        end
    end

    // Sticky overflow: host asked to write past the end of the back buffer.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ovf_r <= 1'b0;
        end else if (iWR_START) begin
            ovf_r <= 1'b0;
        end else if (iWR_REQ && wr_end_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign oCMD_VALID    = cmd_valid_r;
    assign oCMD_WRITE    = cmd_write_r;
    assign oCMD_ADDR     = cmd_addr_r;
    assign oRD_GNT       = rd_gnt_r;
    assign oWR_GNT       = wr_gnt_r;
    assign oFRONT_SEL    = front_r;
    assign oSWAP_PENDING = pend_r;
    assign oWR_OVF       = ovf_r;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter; uses a short frame (256 words)
// so pointer-end and overflow cases are reachable quickly.
module tb_frame_buffer_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST, iNewFrame, iRD_REQ, iWR_REQ, iWR_START, iSWAP_REQ;
    logic        iCMD_READY, iBURST_DONE;
    logic        oRD_GNT, oWR_GNT, oSWAP_PENDING, oFRONT_SEL, oWR_OVF;
    logic        oCMD_VALID, oCMD_WRITE;
    logic [22:0] oCMD_ADDR;

    int total = 0;
    int bad   = 0;

    localparam logic [22:0] B1 = 23'd384000;

    frame_buffer_arbiter #(.FRAME_WORDS(256)) dut (
        .iCLK(iCLK), .iRST(iRST), .iNewFrame(iNewFrame),
        .iRD_REQ(iRD_REQ), .oRD_GNT(oRD_GNT),
        .iWR_REQ(iWR_REQ), .oWR_GNT(oWR_GNT),
        .iWR_START(iWR_START), .iSWAP_REQ(iSWAP_REQ),
        .oSWAP_PENDING(oSWAP_PENDING), .oFRONT_SEL(oFRONT_SEL), .oWR_OVF(oWR_OVF),
        .oCMD_VALID(oCMD_VALID), .oCMD_WRITE(oCMD_WRITE), .oCMD_ADDR(oCMD_ADDR),
        .iCMD_READY(iCMD_READY), .iBURST_DONE(iBURST_DONE)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        rd;
        logic        wr;
        int          stall;
        logic        exp_wr;
        logic [22:0] exp_addr;
    } vec_t;

    vec_t tbl[16];

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Wait for a command, check it, optionally stall, accept it, then finish the burst.
    task automatic expect_cmd(input string name, input logic exp_wr, input logic [22:0] exp_addr,
                              input int stall, input logic nf, input logic ws);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!oCMD_VALID && n < 20);
        check({name, " latency"}, 64'(n), 64'd1);
        check({name, " write"}, 64'(oCMD_WRITE), 64'(exp_wr));
        check({name, " addr"}, 64'(oCMD_ADDR), 64'(exp_addr));
        for (int i = 0; i < stall; i++) begin
            step();
            check({name, " stall hold"}, 64'({oCMD_VALID, oCMD_WRITE, oCMD_ADDR, oRD_GNT, oWR_GNT}),
                  64'({1'b1, exp_wr, exp_addr, 2'b00}));
        end
        iCMD_READY = 1'b1; iNewFrame = nf; iWR_START = ws;
        step();
        iCMD_READY = 1'b0; iNewFrame = 1'b0; iWR_START = 1'b0;
        check({name, " grant"}, 64'({oCMD_VALID, oRD_GNT, oWR_GNT}), 64'({1'b0, ~exp_wr, exp_wr}));
        step();
        check({name, " grant width"}, 64'({oRD_GNT, oWR_GNT}), 64'd0);
        repeat (6) step();
        iBURST_DONE = 1'b1;
        step();
        iBURST_DONE = 1'b0;
    endtask

    task automatic pulse_nf();
        iNewFrame = 1'b1; step(); iNewFrame = 1'b0;
    endtask

    initial begin
        bit saw;
        iRST = 1'b1; iNewFrame = 1'b0; iRD_REQ = 1'b0; iWR_REQ = 1'b0; iWR_START = 1'b0;
        iSWAP_REQ = 1'b0; iCMD_READY = 1'b0; iBURST_DONE = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 0, 1'b0, 23'd0};
        tbl[1]  = '{1'b1, 1'b0, 0, 1'b0, 23'd8};
        tbl[2]  = '{1'b1, 1'b0, 0, 1'b0, 23'd16};
        tbl[3]  = '{1'b1, 1'b0, 5, 1'b0, 23'd24};
        tbl[4]  = '{1'b1, 1'b1, 0, 1'b0, 23'd32};
        tbl[5]  = '{1'b1, 1'b1, 0, 1'b0, 23'd40};
        tbl[6]  = '{1'b1, 1'b1, 0, 1'b0, 23'd48};
        tbl[7]  = '{1'b1, 1'b1, 0, 1'b0, 23'd56};
        tbl[8]  = '{1'b1, 1'b1, 0, 1'b1, B1};
        tbl[9]  = '{1'b1, 1'b1, 0, 1'b0, 23'd64};
        tbl[10] = '{1'b1, 1'b1, 0, 1'b0, 23'd72};
        tbl[11] = '{1'b1, 1'b1, 0, 1'b0, 23'd80};
        tbl[12] = '{1'b1, 1'b1, 0, 1'b0, 23'd88};
        tbl[13] = '{1'b1, 1'b1, 3, 1'b1, B1 + 23'd8};
        tbl[14] = '{1'b0, 1'b1, 0, 1'b1, B1 + 23'd16};
        tbl[15] = '{1'b1, 1'b0, 0, 1'b0, 23'd96};

        // Reset state
        repeat (2) step();
        iRST = 1'b0;
        check("reset flags", 64'({oCMD_VALID, oCMD_WRITE, oRD_GNT, oWR_GNT, oSWAP_PENDING, oFRONT_SEL, oWR_OVF}), 64'd0);
        check("reset addr", 64'(oCMD_ADDR), 64'd0);

        // Arbitration table: read stream, stalled ready, read streak vs waiting write
        for (int k = 0; k < 16; k++) begin
            iRD_REQ = tbl[k].rd;
            iWR_REQ = tbl[k].wr;
            expect_cmd($sformatf("vec%0d", k), tbl[k].exp_wr, tbl[k].exp_addr, tbl[k].stall, 1'b0, 1'b0);
        end
        iRD_REQ = 1'b0; iWR_REQ = 1'b0;

        // Swap requested mid-frame, applied at frame start
        iSWAP_REQ = 1'b1; step(); iSWAP_REQ = 1'b0;
        check("swap pending set", 64'({oSWAP_PENDING, oFRONT_SEL}), 64'b10);
        repeat (3) step();
        check("swap pending held", 64'({oSWAP_PENDING, oFRONT_SEL}), 64'b10);
        pulse_nf();
        check("swap applied", 64'({oSWAP_PENDING, oFRONT_SEL}), 64'b01);
        iWR_START = 1'b1; step(); iWR_START = 1'b0;
        iRD_REQ = 1'b1;
        expect_cmd("rd front1", 1'b0, B1, 0, 1'b0, 1'b0);
        iRD_REQ = 1'b0; iWR_REQ = 1'b1;
        expect_cmd("wr back0", 1'b1, 23'd0, 0, 1'b0, 1'b0);
        iWR_REQ = 1'b0;

        // Swap request coincident with frame start: deferred one frame
        iSWAP_REQ = 1'b1; iNewFrame = 1'b1; step(); iSWAP_REQ = 1'b0; iNewFrame = 1'b0;
        check("swap coincident", 64'({oSWAP_PENDING, oFRONT_SEL}), 64'b11);
        pulse_nf();
        check("swap deferred", 64'({oSWAP_PENDING, oFRONT_SEL}), 64'b00);

        // Frame start coincident with read acceptance: pointer clear wins
        iRD_REQ = 1'b1;
        expect_cmd("rd nf accept", 1'b0, 23'd0, 0, 1'b1, 1'b0);
        expect_cmd("rd after nf", 1'b0, 23'd0, 0, 1'b0, 1'b0);

        // Read to end of frame, then stall until frame start
        for (int i = 1; i < 32; i++) begin
            expect_cmd("rd fill", 1'b0, 23'(i * 8), 0, 1'b0, 1'b0);
        end
        saw = 1'b0;
        repeat (6) begin
            step();
            if (oCMD_VALID) saw = 1'b1;
        end
        check("rd end stall", 64'(saw), 64'd0);
        pulse_nf();
        expect_cmd("rd new frame", 1'b0, 23'd0, 0, 1'b0, 1'b0);
        iRD_REQ = 1'b0;

        // Fill the back buffer, then overflow
        iWR_START = 1'b1; step(); iWR_START = 1'b0;
        iWR_REQ = 1'b1;
        for (int i = 0; i < 32; i++) begin
            expect_cmd("wr fill", 1'b1, B1 + 23'(i * 8), 0, 1'b0, 1'b0);
        end
        saw = 1'b0;
        repeat (4) begin
            step();
            if (oCMD_VALID || oWR_GNT) saw = 1'b1;
        end
        check("wr ovf no grant", 64'(saw), 64'd0);
        check("wr ovf set", 64'(oWR_OVF), 64'd1);
        iWR_START = 1'b1; step(); iWR_START = 1'b0;
        check("wr ovf cleared", 64'(oWR_OVF), 64'd0);
        expect_cmd("wr restart", 1'b1, B1, 0, 1'b0, 1'b0);
        expect_cmd("wr start accept", 1'b1, B1 + 23'd8, 0, 1'b0, 1'b1);
        expect_cmd("wr after start", 1'b1, B1, 0, 1'b0, 1'b0);
        iWR_REQ = 1'b0;

        // Reset while a burst is in flight
        iSWAP_REQ = 1'b1; step(); iSWAP_REQ = 1'b0;
        pulse_nf();
        check("front before rst", 64'(oFRONT_SEL), 64'd1);
        iRD_REQ = 1'b1;
        step();
        check("pre-rst cmd", 64'({oCMD_VALID, oCMD_ADDR}), 64'({1'b1, B1}));
        iCMD_READY = 1'b1; step(); iCMD_READY = 1'b0;
        iRST = 1'b1; step(); iRST = 1'b0;
        check("rst busy flags", 64'({oCMD_VALID, oCMD_WRITE, oRD_GNT, oWR_GNT, oSWAP_PENDING, oFRONT_SEL, oWR_OVF}), 64'd0);
        check("rst busy addr", 64'(oCMD_ADDR), 64'd0);
        expect_cmd("rd after rst", 1'b0, 23'd0, 0, 1'b0, 1'b0);
        iRD_REQ = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares the single SDRAM command port between two requesters: the LCD display read stream (line-FIFO refill bursts) and the PIC32 slide-loader write stream.
- Manages double buffering. Display reads always come from the front buffer and host writes always go to the back buffer. Buffers swap only at a frame boundary.
- Sits between the MTL display timing / SDRAM read FIFO and the SDRAM controller.

Parameters:
- ADDR_W, 23: SDRAM word-address width.
- BURST_LEN, 8: words per burst; pointer increment per granted burst.
- FRAME_WORDS, 384000: words per frame (800x480); must be a multiple of BURST_LEN.
- BUF1_BASE, 384000: word base address of buffer 1. Buffer 0 base is 0.
- MAX_RD_STREAK, 4: consecutive read bursts allowed while a write is pending before the write is forced.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, synchronous, active-high
- iNewFrame  in  1  one-cycle pulse at frame start (x=0, y=0) from display timing
- iRD_REQ  in  1  level: display FIFO below watermark, wants a burst
- oRD_GNT  out  1  one-cycle pulse when a read command is accepted
- iWR_REQ  in  1  level: host write FIFO holds at least BURST_LEN words
- oWR_GNT  out  1  one-cycle pulse when a write command is accepted
- iWR_START  in  1  pulse: host begins a new slide; write pointer reset to 0
- iSWAP_REQ  in  1  pulse: host finished the slide; swap at next iNewFrame
- oSWAP_PENDING  out  1  swap requested, not yet applied
- oFRONT_SEL  out  1  current front (display) buffer index
- oWR_OVF  out  1  sticky: write request made at write pointer = FRAME_WORDS
- oCMD_VALID  out  1  command valid to SDRAM controller
- oCMD_WRITE  out  1  1 = write burst, 0 = read burst
- oCMD_ADDR  out  ADDR_W  burst start word address
- iCMD_READY  in  1  SDRAM controller accepts the command this cycle
- iBURST_DONE  in  1  pulse: last word of the current burst transferred

Behaviour:
- Reset (iRST=1 at a rising edge):
  - All outputs 0; oFRONT_SEL=0.
  - rd_ptr=0, wr_ptr=0, streak=0, state=IDLE.
  - Reset mid-burst abandons the burst without waiting for iBURST_DONE.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE:
  - Selects a requester, latches address and direction, goes to ISSUE.
  - oCMD_VALID rises the cycle after the request is sampled (1-cycle latency).
- Arbitration:
  - Read has priority.
  - Write wins if rd_ptr = FRAME_WORDS, or iRD_REQ=0, or streak = MAX_RD_STREAK.
  - A read is eligible only if rd_ptr < FRAME_WORDS.
  - A write is eligible only if wr_ptr < FRAME_WORDS. If iWR_REQ is asserted with wr_ptr = FRAME_WORDS, set oWR_OVF and grant nothing.
- Streak counter:
  - Increments on each accepted read while iWR_REQ=1.
  - Clears on an accepted write or when iWR_REQ=0.
  - Saturates at MAX_RD_STREAK.
- ISSUE:
  - oCMD_VALID=1; oCMD_ADDR and oCMD_WRITE held stable until iCMD_READY.
  - On iCMD_READY: pulse oRD_GNT or oWR_GNT, advance the chosen pointer by BURST_LEN, go to BUSY.
- BUSY:
  - oCMD_VALID=0.
  - On iBURST_DONE go to IDLE; the next command can be issued one cycle later.
  - iBURST_DONE in any other state is ignored.
- Address computation:
  - Read: base(oFRONT_SEL) + rd_ptr.
  - Write: base(~oFRONT_SEL) + wr_ptr.
  - Computed at ADDR_W width, no truncation.
- Frame boundary (iNewFrame):
  - rd_ptr returns to 0.
  - If oSWAP_PENDING=1, toggle oFRONT_SEL and clear oSWAP_PENDING in the same cycle.
  - A command already in ISSUE/BUSY keeps its latched address.
  - If iNewFrame coincides with a read acceptance, the clear wins: rd_ptr=0, not 0+BURST_LEN.
- iSWAP_REQ sets oSWAP_PENDING.
  - iSWAP_REQ coincident with iNewFrame: set pending; swap at the following frame.
- iWR_START:
  - Clears wr_ptr and oWR_OVF.
  - Coincident with a write acceptance: the clear wins.
- rd_ptr reaching FRAME_WORDS is not a wrap; reads stall until iNewFrame.

Decomposition:
- Package fb_arb_pkg:
  - State enum {IDLE, ISSUE, BUSY}.
  - Buffer-base constants and a base(sel) function.
  - Pointer width localparam = $clog2(FRAME_WORDS+1).
- Sub-module fb_burst_ptr, instantiated twice (read and write):
  - Ports: clear, advance, count output, at_end flag.
  - Clear has priority over advance.

Test Plan:
- Reset, then iRD_REQ=1 with iCMD_READY=1 and iBURST_DONE 8 cycles after each grant -> addresses 0, 8, 16, ...; oRD_GNT is one cycle wide; oCMD_VALID one cycle after request.
- iRD_REQ and iWR_REQ held high, front=0 -> reads at 0, 8, 16, 24, then a write at 384000, then a read at 32; streak behaviour repeats.
- iSWAP_REQ mid-frame -> oSWAP_PENDING=1 until iNewFrame; then oFRONT_SEL=1, next read at 384000, next write at 0.
- iCMD_READY held low 5 cycles -> oCMD_VALID, oCMD_ADDR and oCMD_WRITE stable all 5 cycles; exactly one grant pulse.
- Write 48000 bursts after iWR_START, then iWR_REQ again -> oWR_OVF=1 and no grant; iWR_START clears oWR_OVF and the next write goes to back base + 0.
- iRST asserted while in BUSY -> next cycle all outputs 0, state IDLE, oFRONT_SEL=0; a pending iRD_REQ is re-issued at address 0.
